difftest_trap_collector: RTL
============================

// Module: difftest_trap_collector
// PURPOSE
//  Upstream feeder of the difftest trap-event sink. Sits at the core's commit stage: counts cycles and
//  retired instructions, detects the good/bad trap instruction, latches its PC/code, flags WFI stalls,
//  and drives the sink's enable/io_* inputs with one registered snapshot per cycle. Also tells the core to halt.
// PARAMETERS
//  COMMIT_WIDTH  2     commit lanes per cycle; lane 0 is oldest.
//  WFI_TIMEOUT   1024  consecutive wfi_active cycles before a one-cycle hasWFI pulse; must be >= 1.
//  CORE_ID       0     constant driven on io_coreid (8 bits).
//  MAX_CYCLES    64'd1_000_000  cycle limit; used only with DIFFTEST_TRAP_CYCLE_LIMIT_EN.
// PORTS
//  clock          in   1            single clock; all logic posedge.
//  reset_n        in   1            synchronous, active-low reset.
//  commit_valid   in   CW           lane i retires an instruction this cycle.
//  commit_is_trap in   CW           lane i instruction is the trap opcode; ignored unless commit_valid[i].
//  commit_pc      in   64*CW        lane i PC, lane i at [64*i +: 64].
//  commit_code    in   32*CW        lane i trap code (a0 low word), same packing.
//  wfi_active     in   1            core is stalled in WFI this cycle.
//  enable         out  1            sink strobe.
//  io_hasTrap     out  1            sticky: trap retired.
//  io_cycleCnt    out  64           cycles since reset release.
//  io_instrCnt    out  64           instructions retired.
//  io_hasWFI      out  1            one-cycle WFI-timeout pulse.
//  io_code        out  32           latched trap code.
//  io_pc          out  64           latched trap PC.
//  io_coreid      out  8            CORE_ID.
//  halt_req       out  1            to core: stop committing; high in HALTED.
// BEHAVIOUR
//  Reset (reset_n==0 at posedge): all outputs 0 except io_coreid=CORE_ID; state=RUN; counters, WFI count 0.
//  Reset mid-operation, including HALTED, fully returns to this state the next cycle.
//  All io_*/enable registered: commit inputs in cycle N are visible on outputs in cycle N+1.
//  States: RUN -> (trap retired) -> HALTED; HALTED exits only by reset. One-cycle trip through the
//   transition: the capture cycle loads io_hasTrap/io_pc/io_code and enters HALTED together.
//  RUN: enable=1 every cycle after the first post-reset cycle. cycleCnt += 1 per cycle, wraps at 2^64.
//   instrCnt += popcount of valid lanes at or below the trapping lane; lanes above it are dropped.
//   Without a trap, all valid lanes count. Non-contiguous valid masks are counted as given.
//  Trap select: lowest lane i with commit_valid[i]&commit_is_trap[i]; its pc/code are latched.
//   Simultaneous traps in several lanes: lowest wins; the others count as nothing.
//  HALTED: halt_req=1; cycleCnt, instrCnt, pc, code frozen; io_hasTrap=1; enable=1 for exactly one
//   cycle (the first HALTED cycle, carrying the final snapshot), then 0. commit_* inputs ignored.
//  WFI: wfi_cnt increments while wfi_active in RUN, clears on any cycle wfi_active=0 or any commit.
//   When wfi_cnt reaches WFI_TIMEOUT-1 while wfi_active, io_hasWFI=1 next cycle for one cycle and wfi_cnt=0.
//   WFI logic idle in HALTED; io_hasWFI=0.
//   A trap in the same cycle as the WFI threshold: trap wins, no WFI pulse.
// CONFIGURATION
//  DIFFTEST_TRAP_CYCLE_LIMIT_EN defined: in RUN, when cycleCnt would reach MAX_CYCLES with no trap
//   that cycle, forced trap: io_code=32'hFFFF_FFFF, io_pc=PC of highest valid lane this cycle,
//   else last committed PC (0 if none); enter HALTED as for a real trap. A real trap in the
//   same cycle takes priority. Without the macro: no limit logic, MAX_CYCLES unused, runs indefinitely.
// TESTING
//  Release reset, 5 idle cycles -> enable=1, io_cycleCnt counts 1..5, io_instrCnt=0, io_hasTrap=0.
//  CW=2: valid=2'b11 for 3 cycles, then valid=2'b11, is_trap=2'b01, pc0=64'h8000_0100, code0=0
//   -> instrCnt 7 (lane1 dropped), hasTrap=1, pc=64'h8000_0100, code=0, halt_req=1; one more enable, then 0.
//  valid=2'b11, is_trap=2'b11, codes 5/9 -> lane 0 wins: code=5, instrCnt+1.
//  WFI_TIMEOUT=4: wfi_active held 10 cycles, no commits -> hasWFI pulses on cycles 4 and 8 after
//   onset (single-cycle); a commit at cycle 3 restarts the count.
//  Reset asserted in HALTED -> next cycle all outputs 0, state RUN; cycleCnt restarts from 1.
//  With DIFFTEST_TRAP_CYCLE_LIMIT_EN, MAX_CYCLES=20, no trap -> forced trap at cycleCnt 20,
//   code=32'hFFFF_FFFF, halt_req=1; without the macro -> counting continues past 20, no halt.

Source files
------------

// File: rtl/difftest_trap_collector.sv
// Commit-stage feeder for the difftest trap-event sink: counts cycles and retired instructions,
// latches the trap PC/code, flags WFI stalls, and requests a core halt. Optional cycle limit: DIFFTEST_TRAP_CYCLE_LIMIT_EN.
module difftest_trap_collector #(
    parameter int unsigned COMMIT_WIDTH = 2,
    parameter int unsigned WFI_TIMEOUT  = 1024,
    parameter logic [7:0]  CORE_ID      = 8'd0,
    parameter logic [63:0] MAX_CYCLES   = 64'd1_000_000
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [COMMIT_WIDTH-1:0]     commit_valid,
    input  logic [COMMIT_WIDTH-1:0]     commit_is_trap,
    input  logic [64*COMMIT_WIDTH-1:0]  commit_pc,
    input  logic [32*COMMIT_WIDTH-1:0]  commit_code,
    input  logic                        wfi_active,
    output logic                        enable,
    output logic                        io_hasTrap,
    output logic [63:0]                 io_cycleCnt,
    output logic [63:0]                 io_instrCnt,
    output logic                        io_hasWFI,
    output logic [31:0]                 io_code,
    output logic [63:0]                 io_pc,
    output logic [7:0]                  io_coreid,
    output logic                        halt_req
);

    localparam int unsigned CNT_W = $clog2(COMMIT_WIDTH + 1);
    localparam int unsigned WFI_W = $clog2(WFI_TIMEOUT) + 1;
`ifdef DIFFTEST_TRAP_CYCLE_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    typedef enum logic {RUN, HALTED} state_t;

    state_t             state_q, state_d;
    logic [WFI_W-1:0]   wfi_cnt_q, wfi_cnt_d;
    logic               enable_d, has_trap_d, has_wfi_d, halt_d;
    logic [63:0]        cycle_d, instr_d, pc_d;
    logic [31:0]        code_d;

    logic               trap_hit, any_valid, limit_hit;
    logic [CNT_W-1:0]   lane_cnt;
    logic [63:0]        trap_pc, top_pc, forced_pc, cycle_nxt;
    logic [31:0]        trap_code;

    // Lane scan: count valid lanes up to and including the oldest trapping lane.
    always_comb begin
        trap_hit  = 1'b0;
        any_valid = 1'b0;
        lane_cnt  = '0;
        trap_pc   = '0;
        trap_code = '0;
        top_pc    = '0;
        for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
            if (commit_valid[i]) begin
                any_valid = 1'b1;
                top_pc    = commit_pc[64*i +: 64];
                if (!trap_hit) begin
                    lane_cnt = lane_cnt + CNT_W'(1);
                    if (commit_is_trap[i]) begin
                        trap_hit  = 1'b1;
                        trap_pc   = commit_pc[64*i +: 64];
                        trap_code = commit_code[32*i +: 32];
                    end
                end
            end
        end
    end

    assign cycle_nxt = io_cycleCnt + 64'd1;
    assign limit_hit = LIMIT_EN && (cycle_nxt == MAX_CYCLES);

`ifdef DIFFTEST_TRAP_CYCLE_LIMIT_EN
    logic [63:0] last_pc_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            last_pc_q <= '0;
        end else if (state_q == RUN && any_valid) begin
            last_pc_q <= top_pc;
        end
    end

    assign forced_pc = any_valid ? top_pc : last_pc_q;
`else
    assign forced_pc = 64'd0;
`endif

    // Next-state and next-snapshot logic.
    always_comb begin
        state_d    = state_q;
        wfi_cnt_d  = wfi_cnt_q;
        enable_d   = enable;
        has_trap_d = io_hasTrap;
        has_wfi_d  = 1'b0;
        halt_d     = halt_req;
        cycle_d    = io_cycleCnt;
        instr_d    = io_instrCnt;
        pc_d       = io_pc;
        code_d     = io_code;
        case (state_q)
            RUN: begin
                enable_d = 1'b1;
                cycle_d  = cycle_nxt;
                instr_d  = io_instrCnt + 64'(lane_cnt);
                if (trap_hit || limit_hit) begin
                    has_trap_d = 1'b1;
                    halt_d     = 1'b1;
                    wfi_cnt_d  = '0;
                    state_d    = HALTED;
                    pc_d       = trap_hit ? trap_pc : forced_pc;
                    code_d     = trap_hit ? trap_code : 32'hFFFF_FFFF;
                end else if (!wfi_active || any_valid) begin
                    wfi_cnt_d = '0;
                end else if (wfi_cnt_q == WFI_W'(WFI_TIMEOUT - 1)) begin
                    has_wfi_d = 1'b1;
                    wfi_cnt_d = '0;
                end else begin
                    wfi_cnt_d = wfi_cnt_q + WFI_W'(1);
                end
            end
            HALTED: begin
                enable_d  = 1'b0;
                halt_d    = 1'b1;
                wfi_cnt_d = '0;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= RUN;
            wfi_cnt_q   <= '0;
            enable      <= 1'b0;
            io_hasTrap  <= 1'b0;
            io_cycleCnt <= '0;
            io_instrCnt <= '0;
            io_hasWFI   <= 1'b0;
            io_code     <= '0;
            io_pc       <= '0;
            io_coreid   <= CORE_ID;
            halt_req    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wfi_cnt_q   <= wfi_cnt_d;
            enable      <= enable_d;
            io_hasTrap  <= has_trap_d;
            io_cycleCnt <= cycle_d;
            io_instrCnt <= instr_d;
            io_hasWFI   <= has_wfi_d;
            io_code     <= code_d;
            io_pc       <= pc_d;
            io_coreid   <= CORE_ID;
            halt_req    <= halt_d;
        end
    end

endmodule
